// File: rtl/pcpu_pkg.sv
// ============================================================================
// Module      : pcpu_pkg
// Description : Shared PCPU decode constants and hazard sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_MDU_WAIT = 2'd2
  } hz_state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_haz_detect.sv
// ============================================================================
// Module      : haz_detect
// Description : Combinational stall-demand encoder (stall length n, MDU request).
//               Optional MDU interlock enabled by macro HAZ_MDU_INTERLOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module haz_detect
  import pcpu_pkg::*;
#(
  parameter int unsigned MAX_STALL = 2,
  parameter int unsigned CW        = 2
) (
  input  logic [4:0]    Rs_id,
  input  logic [4:0]    Rt_id,
  input  logic [5:0]    op_id,
  input  logic [5:0]    funct_id,
  input  logic          UseRt_id,
  input  logic          Jump_id,
  input  logic          Branch_id,
  input  logic [4:0]    Rd_ex,
  input  logic          RegWrite_ex,
  input  logic          MemRead_ex,
  input  logic [4:0]    Rd_mem,
  input  logic          MemRead_mem,
  input  logic          MDU_busy,
  output logic [CW-1:0] n_o,
  output logic          mdu_req_o
);

  logic        rs_ex, rt_ex, rs_mem, rt_mem;
  logic        ctrl_id, ctrl_ex, ctrl_mem, load_use;
  int unsigned n_raw;

  // Register 0 is hard-wired, so a match on it is never a hazard.
  assign rs_ex  = (Rs_id != 5'd0) && (Rs_id == Rd_ex);
  assign rt_ex  = (Rt_id != 5'd0) && (Rt_id == Rd_ex);
  assign rs_mem = (Rs_id != 5'd0) && (Rs_id == Rd_mem);
  assign rt_mem = (Rt_id != 5'd0) && (Rt_id == Rd_mem);

  // Branches compare rs and rt in ID; jr/jalr only read rs.
  assign ctrl_id  = Branch_id || (Jump_id && (op_id == OP_RTYPE));
  assign ctrl_ex  = ctrl_id && (rs_ex  || (Branch_id && rt_ex));
  assign ctrl_mem = ctrl_id && (rs_mem || (Branch_id && rt_mem));
  assign load_use = MemRead_ex && (rs_ex || (rt_ex && UseRt_id));

  always_comb begin
    n_raw = 0;
    if (load_use)                  n_raw = 1;
    if (ctrl_mem && MemRead_mem)   n_raw = 1;
    if (ctrl_ex && RegWrite_ex)    n_raw = 1;
    if (ctrl_ex && MemRead_ex)     n_raw = 2;
  end

  assign n_o = CW'((n_raw > MAX_STALL) ? MAX_STALL : n_raw);

`ifdef HAZ_MDU_INTERLOCK_EN
  assign mdu_req_o = (op_id == OP_RTYPE) && MDU_busy &&
                     ((funct_id == FN_MFHI) || (funct_id == FN_MFLO));
`else
  logic unused_mdu;
  assign unused_mdu = ^{funct_id, MDU_busy};
  assign mdu_req_o  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : PCPU stall/flush sequencer (RUN/STALL/MDU_WAIT FSM and counters).
//               Optional MDU interlock enabled by macro HAZ_MDU_INTERLOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import pcpu_pkg::*;
#(
  parameter int unsigned MAX_STALL   = 2,
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs_id,
  input  logic [4:0] Rt_id,
  input  logic [5:0] op_id,
  input  logic [5:0] funct_id,
  input  logic       UseRt_id,
  input  logic       Jump_id,
  input  logic       Branch_id,
  input  logic       Taken_id,
  input  logic [4:0] Rd_ex,
  input  logic       RegWrite_ex,
  input  logic       MemRead_ex,
  input  logic [4:0] Rd_mem,
  input  logic       MemRead_mem,
  input  logic       MDU_busy,
  output logic       PCWrite_o,
  output logic       IFIDWrite_o,
  output logic       IDEX_bubble_o,
  output logic       IFID_flush_o,
  output logic       hz_err_o
);

  localparam int unsigned CW = $clog2(MAX_STALL + 1);
  localparam int unsigned WW = $clog2(MDU_TIMEOUT + 1);

  hz_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] n;
  logic          mdu_req;
  logic          stall, flush;

  haz_detect #(.MAX_STALL(MAX_STALL), .CW(CW)) u_detect (
    .Rs_id      (Rs_id),
    .Rt_id      (Rt_id),
    .op_id      (op_id),
    .funct_id   (funct_id),
    .UseRt_id   (UseRt_id),
    .Jump_id    (Jump_id),
    .Branch_id  (Branch_id),
    .Rd_ex      (Rd_ex),
    .RegWrite_ex(RegWrite_ex),
    .MemRead_ex (MemRead_ex),
    .Rd_mem     (Rd_mem),
    .MemRead_mem(MemRead_mem),
    .MDU_busy   (MDU_busy),
    .n_o        (n),
    .mdu_req_o  (mdu_req)
  );

`ifdef HAZ_MDU_INTERLOCK_EN
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  assign hz_err_o = err_q;
`else
  logic unused_mdu;
  assign unused_mdu = mdu_req;
  assign hz_err_o   = 1'b0;
`endif

  // The RUN cycle that detects demand is the first stall cycle, so STALL
  // only covers the remaining n-1 cycles and cnt holds that remainder.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
`ifdef HAZ_MDU_INTERLOCK_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (n != '0) begin
          stall = 1'b1;
          cnt_d = n - CW'(1);
          if (n > CW'(1)) state_d = ST_STALL;
        end
`ifdef HAZ_MDU_INTERLOCK_EN
        else if (mdu_req) begin
          stall   = 1'b1;
          wait_d  = '0;
          state_d = ST_MDU_WAIT;
        end
`endif
        else if (Taken_id) begin
          flush = 1'b1;
        end
      end
      ST_STALL: begin
        stall = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = ST_RUN;
      end
`ifdef HAZ_MDU_INTERLOCK_EN
      ST_MDU_WAIT: begin
        stall = 1'b1;
        if (!MDU_busy) begin
          state_d = ST_RUN;
        end else begin
          wait_d = wait_q + WW'(1);
          if (wait_q == WW'(MDU_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
`endif
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
`ifdef HAZ_MDU_INTERLOCK_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef HAZ_MDU_INTERLOCK_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign PCWrite_o     = rst | ~stall;
  assign IFIDWrite_o   = rst | ~stall;
  assign IDEX_bubble_o = ~rst & stall;
  assign IFID_flush_o  = ~rst & flush;

endmodule

`default_nettype wire
